// File: rtl/led_waterfall_pkg.sv
// Shared mode codes and FSM state encoding for the waterfall LED sequencer.
package led_waterfall_pkg;

    localparam logic [1:0] MODE_DOT    = 2'b00;
    localparam logic [1:0] MODE_FILL   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/step_prescaler.sv
// Divides the rate strobe by 1/2/4/8; adv is a same-cycle pulse on a qualifying strobe.
module step_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       step_tick,
    input  logic [1:0] speed,
    output logic       adv
);

    logic [2:0] pre_cnt_q, pre_cnt_d;
    logic [3:0] thresh;

    // >= compare so a speed lowered below the current count advances on the next strobe
    assign thresh = (4'd1 << speed) - 4'd1;
    assign adv    = en && step_tick && ({1'b0, pre_cnt_q} >= thresh);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (en && step_tick) begin
            pre_cnt_d = adv ? 3'd0 : pre_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/led_waterfall_seq.sv
// Waterfall LED sequencer: IDLE/RUN/PAUSE FSM, position update and registered LED decode.
// Define LED_WATERFALL_BOUNCE_EN to enable the bounce pattern on mode 10 (otherwise decoded as dot).
module led_waterfall_seq
    import led_waterfall_pkg::*;
#(
    parameter int LED_NUM = 8,
    parameter int POS_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_tick,
    input  logic               run,
    input  logic               clr,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    output logic [LED_NUM-1:0] led,
    output logic               step,
    output logic               wrap
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_NUM - 1);

    state_e             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic               adv, adv_en;
    logic               is_fill, mirror_en;
    logic [LED_NUM-1:0] dec;

    // A strobe only counts while RUN persists, so step/wrap never land outside RUN
    assign adv_en = (state_q == ST_RUN) && run && !clr;

    step_prescaler u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr || (state_q == ST_IDLE)),
        .en        (adv_en),
        .step_tick (step_tick),
        .speed     (speed),
        .adv       (adv)
    );

`ifdef LED_WATERFALL_BOUNCE_EN
    logic up_q, up_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q <= 1'b1;
        end else begin
            up_q <= up_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
`ifdef LED_WATERFALL_BOUNCE_EN
        up_d    = up_q;
`endif
        if (clr) begin
            state_d = ST_IDLE;
            pos_d   = '0;
`ifdef LED_WATERFALL_BOUNCE_EN
            up_d    = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_RUN;
                        pos_d   = '0;
`ifdef LED_WATERFALL_BOUNCE_EN
                        up_d    = 1'b1;
`endif
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_PAUSE;
                    end
                    if (adv) begin
                        step_d = 1'b1;
                        pos_d  = (pos_q >= POS_LAST) ? '0 : pos_q + 1'b1;
                        wrap_d = (pos_q >= POS_LAST);
`ifdef LED_WATERFALL_BOUNCE_EN
                        // Turn at either end without repeating it; also recovers from pos at the top with up set
                        if (mode == MODE_BOUNCE) begin
                            if ((up_q && pos_q < POS_LAST) || pos_q == '0) begin
                                pos_d  = pos_q + 1'b1;
                                up_d   = (pos_q + 1'b1) != POS_LAST;
                                wrap_d = 1'b0;
                            end else begin
                                pos_d  = pos_q - 1'b1;
                                up_d   = (pos_q == POS_W'(1));
                                wrap_d = (pos_q == POS_W'(1));
                            end
                        end
`endif
                    end
                end
                ST_PAUSE: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (mode)
            MODE_FILL:             is_fill = 1'b1;
            MODE_DOT, MODE_BOUNCE: is_fill = 1'b0;
            default:               is_fill = 1'b0;
        endcase
`ifdef LED_WATERFALL_BOUNCE_EN
        mirror_en = dir && (mode != MODE_BOUNCE);
`else
        mirror_en = dir;
`endif
        dec = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            dec[i] = is_fill ? (POS_W'(i) <= pos_q) : (POS_W'(i) == pos_q);
        end
        led_d = '0;
        if (!clr && state_q != ST_IDLE) begin
            for (int i = 0; i < LED_NUM; i++) begin
                led_d[i] = mirror_en ? dec[LED_NUM-1-i] : dec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            led_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_waterfall_seq.sv
// Self-checking bench for led_waterfall_seq against a sweep-level reference model.
module tb_led_waterfall_seq;

`ifdef LED_WATERFALL_BOUNCE_EN
    localparam bit BOUNCE_ON = 1'b1;
`else
    localparam bit BOUNCE_ON = 1'b0;
`endif
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_tick = 1'b0;
    logic       run = 1'b0;
    logic       clr = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] speed = 2'b00;
    logic [7:0] led;
    logic       step;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 running, 2 paused; k is the index within a bounce round trip
    int         m_state, m_pos, m_pre, m_k;
    logic [7:0] m_led;
    logic       m_step, m_wrap;

    led_waterfall_seq #(.LED_NUM(8), .POS_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_tick (step_tick),
        .run       (run),
        .clr       (clr),
        .dir       (dir),
        .mode      (mode),
        .speed     (speed),
        .led       (led),
        .step      (step),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pattern(input int p, input logic [1:0] md, input logic d);
        logic [7:0] v, r;
        if (md == 2'b01) v = 8'((2 << p) - 1);
        else             v = 8'(1 << p);
        r = v;
        if (d && !(BOUNCE_ON && md == 2'b10))
            for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_pre = 0; m_k = 0;
        m_led = 8'h00; m_step = 1'b0; m_wrap = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] n_led;
        logic       n_step, n_wrap;
        n_led  = (m_state == 0 || clr) ? 8'h00 : pattern(m_pos, mode, dir);
        n_step = 1'b0;
        n_wrap = 1'b0;
        if (clr) begin
            m_state = 0; m_pos = 0; m_pre = 0; m_k = 0;
        end else if (m_state == 0) begin
            if (run) begin m_state = 1; m_pos = 0; m_pre = 0; m_k = 0; end
        end else if (m_state == 1) begin
            if (!run) m_state = 2;
            else if (step_tick) begin
                if (m_pre >= (1 << speed) - 1) begin
                    m_pre  = 0;
                    n_step = 1'b1;
                    if (BOUNCE_ON && mode == 2'b10) begin
                        m_k    = (m_k + 1) % (2*N - 2);
                        m_pos  = (m_k < N) ? m_k : 2*N - 2 - m_k;
                        n_wrap = (m_k == 0);
                    end else begin
                        m_pos  = (m_pos + 1) % N;
                        m_k    = m_pos;
                        n_wrap = (m_pos == 0);
                    end
                end else begin
                    m_pre++;
                end
            end
        end else if (run) begin
            m_state = 1;
        end
        m_led = n_led; m_step = n_step; m_wrap = n_wrap;
    endtask

    task automatic cyc(input logic tk);
        step_tick = tk;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic go_idle();
        clr = 1'b1; run = 1'b0;
        cyc(1'b0);
        clr = 1'b0;
        cyc(1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            checks++;
            if ({led, step, wrap} !== 10'h000) begin
                errors++;
                $display("FAIL reset_state: led=%h step=%b wrap=%b, want led=00 step=0 wrap=0", led, step, wrap);
            end
        end
        rst_n = 1'b1;
        cyc(1'b0);
    endtask

    task automatic test_dot();
        int nwrap = 0;
        go_idle();
        mode = 2'b00; dir = 1'b0; speed = 2'd0; run = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 160; i++) begin
            cyc((i % 4) == 0);
            if (wrap === 1'b1) nwrap++;
            checks++;
            if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL dot_cycle%0d: led=%h step=%b wrap=%b, want led=%h step=%b wrap=%b",
                         i, led, step, wrap, m_led, m_step, m_wrap);
            end
        end
        checks++;
        if (nwrap !== 5) begin
            errors++;
            $display("FAIL dot_wrap_count: got %0d, want 5", nwrap);
        end
    endtask

    task automatic test_fill();
        int nstep = 0;
        go_idle();
        mode = 2'b01; dir = 1'b1; speed = 2'd1; run = 1'b1;
        cyc(1'b0);
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL fill_entry: led=%h, want 00", led);
        end
        cyc(1'b0);
        checks++;
        if (led !== 8'h80) begin
            errors++;
            $display("FAIL fill_first: led=%h, want 80", led);
        end
        for (int i = 0; i < 96; i++) begin
            cyc((i % 4) == 0);
            if (step === 1'b1) nstep++;
            checks++;
            if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL fill_cycle%0d: led=%h step=%b wrap=%b, want led=%h step=%b wrap=%b",
                         i, led, step, wrap, m_led, m_step, m_wrap);
            end
        end
        checks++;
        if (nstep !== 12) begin
            errors++;
            $display("FAIL fill_step_count: got %0d, want 12", nstep);
        end
    endtask

    task automatic test_bounce();
        int nwrap = 0;
        go_idle();
        mode = 2'b10; dir = 1'($urandom_range(0, 1)); speed = 2'd0; run = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 120; i++) begin
            cyc((i % 4) == 0);
            if (wrap === 1'b1) nwrap++;
            checks++;
            if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL bounce_cycle%0d: led=%h step=%b wrap=%b, want led=%h step=%b wrap=%b",
                         i, led, step, wrap, m_led, m_step, m_wrap);
            end
        end
        checks++;
        if (nwrap !== (BOUNCE_ON ? 2 : 3)) begin
            errors++;
            $display("FAIL bounce_wrap_count: got %0d, want %0d", nwrap, BOUNCE_ON ? 2 : 3);
        end
    endtask

    task automatic test_pause_clear();
        int  i;
        bit  seen;
        go_idle();
        mode = 2'b00; dir = 1'b0; speed = 2'd0; run = 1'b1;
        cyc(1'b0);
        i = 0;
        while (led !== 8'h08 && i < 64) begin
            cyc((i % 4) == 0);
            i++;
        end
        checks++;
        if (led !== 8'h08) begin
            errors++;
            $display("FAIL pause_reach08: led=%h, want 08", led);
        end
        run = 1'b0;
        for (int j = 0; j < 40; j++) begin
            cyc((j % 4) == 0);
            checks++;
            if ({led, step, wrap} !== {8'h08, 2'b00} || led !== m_led) begin
                errors++;
                $display("FAIL pause_hold%0d: led=%h step=%b wrap=%b, want led=08 step=0 wrap=0", j, led, step, wrap);
            end
        end
        run = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 16 && !seen; j++) begin
            cyc((j % 4) == 1);
            seen = (step === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL resume_step: no step within 16 cycles, want one");
        end
        cyc(1'b0);
        checks++;
        if (led !== 8'h10) begin
            errors++;
            $display("FAIL resume_led: led=%h, want 10", led);
        end
        clr = 1'b1;
        cyc(1'b1);
        clr = 1'b0;
        checks++;
        if ({led, step, wrap} !== 10'h000) begin
            errors++;
            $display("FAIL clr_priority: led=%h step=%b wrap=%b, want 00/0/0", led, step, wrap);
        end
        run = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cyc((j % 4) == 0);
            checks++;
            if ({led, step, wrap} !== 10'h000) begin
                errors++;
                $display("FAIL clr_idle%0d: led=%h step=%b wrap=%b, want 00/0/0", j, led, step, wrap);
            end
        end
    endtask

    task automatic test_speed_change();
        go_idle();
        mode = 2'b00; dir = 1'b0; speed = 2'd3; run = 1'b1;
        cyc(1'b0);
        for (int j = 0; j < 20; j++) begin
            cyc((j % 4) == 0);
            checks++;
            if (step !== 1'b0) begin
                errors++;
                $display("FAIL speed3_nostep%0d: step=%b, want 0", j, step);
            end
        end
        speed = 2'd0;
        cyc(1'b1);
        checks++;
        if (step !== 1'b1 || m_step !== 1'b1) begin
            errors++;
            $display("FAIL speed_drop_adv: step=%b, want 1", step);
        end
        cyc(1'b1);
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL speed_drop_next: step=%b, want 1", step);
        end
        cyc(1'b0);
        checks++;
        if (led !== 8'h04 || led !== m_led) begin
            errors++;
            $display("FAIL speed_drop_led: led=%h, want 04", led);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        go_idle();
        mode = 2'b00; dir = 1'b0; speed = 2'd0; run = 1'b1;
        cyc(1'b0);
        i = 0;
        while (led !== 8'h20 && i < 64) begin
            cyc((i % 4) == 0);
            i++;
        end
        checks++;
        if (led !== 8'h20) begin
            errors++;
            $display("FAIL midreset_reach20: led=%h, want 20", led);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led, step, wrap} !== 10'h000) begin
            errors++;
            $display("FAIL midreset_async: led=%h step=%b wrap=%b, want 00/0/0", led, step, wrap);
        end
        model_reset();
        cyc(1'b1);
        rst_n = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        checks++;
        if (led !== 8'h01) begin
            errors++;
            $display("FAIL midreset_restart: led=%h, want 01", led);
        end
    endtask

    task automatic test_random();
        logic [1:0] md;
        go_idle();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                md = 2'($urandom_range(0, 3));
                if (BOUNCE_ON && md == 2'b10) md = 2'b01;
                mode = md;
            end
            if ($urandom_range(0, 31) == 0) dir = ~dir;
            if ($urandom_range(0, 63) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) run = ~run;
            clr = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 2) == 0);
            clr = 1'b0;
            checks++;
            if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL random_cycle%0d: led=%h step=%b wrap=%b, want led=%h step=%b wrap=%b",
                         i, led, step, wrap, m_led, m_step, m_wrap);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dot();
        test_fill();
        test_bounce();
        test_pause_clear();
        test_speed_change();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
